audio_pwm_encoder: RTL and testbench



---
 rtl/audio_pwm_encoder_pkg.sv | 32 +++
 rtl/audio_pwm_period_counter.sv | 48 ++++
 rtl/audio_pwm_encoder.sv | 134 +++++++++++++
 tb/tb_audio_pwm_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pwm_encoder_pkg.sv
// Shared constants and state encoding for the audio PWM encoder.
// Pure declarations; no logic, no latency, no flow control.
`ifndef AUDIO_BIT_WIDTH_VOLUME
`define AUDIO_BIT_WIDTH_VOLUME 8
`endif
`ifndef AUDIO_INITIAL_VOLUME
`define AUDIO_INITIAL_VOLUME 128
`endif
`ifndef AUDIO_PWM_RAMP_STEP
`define AUDIO_PWM_RAMP_STEP 16
`endif
`ifndef AUDIO_PWM_ST_IDLE
`define AUDIO_PWM_ST_IDLE 2'd0
`define AUDIO_PWM_ST_RAMP_UP 2'd1
`define AUDIO_PWM_ST_PLAY 2'd2
`define AUDIO_PWM_ST_RAMP_DOWN 2'd3
`endif

package audio_pwm_encoder_pkg;

  localparam int unsigned DEF_VOL_WIDTH      = `AUDIO_BIT_WIDTH_VOLUME;
  localparam int unsigned DEF_INITIAL_VOLUME = `AUDIO_INITIAL_VOLUME;
  localparam int unsigned DEF_RAMP_STEP      = `AUDIO_PWM_RAMP_STEP;

  typedef enum logic [1:0] {
    ST_IDLE      = `AUDIO_PWM_ST_IDLE,
    ST_RAMP_UP   = `AUDIO_PWM_ST_RAMP_UP,
    ST_PLAY      = `AUDIO_PWM_ST_PLAY,
    ST_RAMP_DOWN = `AUDIO_PWM_ST_RAMP_DOWN
  } pwm_state_e;

endpackage

// File: rtl/audio_pwm_period_counter.sv
// PWM period counter and per-sample period repeat counter; strobes are combinational
// from the registered counts. No backpressure: counts freely while run is high.
module audio_pwm_period_counter #(
  parameter int unsigned CNT_WIDTH          = 8,
  parameter int unsigned PERIODS_PER_SAMPLE = 1
) (
  input  logic                 clk_audio,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear_rep,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 period_end,
  output logic                 sample_end
);

  localparam int unsigned REP_WIDTH =
    (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [REP_WIDTH-1:0] REP_LAST = REP_WIDTH'(PERIODS_PER_SAMPLE - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [REP_WIDTH-1:0] rep_q, rep_d;

  always_comb begin
    period_end = (cnt_q == '1);
    sample_end = period_end && (rep_q == REP_LAST);
    // Held at zero while stopped so the first period after start is full length.
    cnt_d      = run ? cnt_q + 1'b1 : '0;
    rep_d      = rep_q;
    if (clear_rep) begin
      rep_d = '0;
    end else if (run && period_end) begin
      rep_d = (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      cnt_q <= '0;
      rep_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/audio_pwm_encoder.sv
// Volume sample to PWM encoder with pop-free ramps and amplifier shutdown control.
// pwm is 1 cycle behind the period counter; upstream is paced by the sample_req strobe.
module audio_pwm_encoder
  import audio_pwm_encoder_pkg::*;
#(
  parameter int unsigned VOL_WIDTH          = DEF_VOL_WIDTH,
  parameter int unsigned INITIAL_VOLUME     = DEF_INITIAL_VOLUME,
  parameter int unsigned RAMP_STEP          = DEF_RAMP_STEP,
  parameter int unsigned PERIODS_PER_SAMPLE = 1
) (
  input  logic                 clk_audio,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [VOL_WIDTH-1:0] vol,
  output logic                 sample_req,
  output logic                 pwm,
  output logic                 shutdown_n
);

  localparam logic [VOL_WIDTH:0] INIT_EXT = (VOL_WIDTH + 1)'(INITIAL_VOLUME);
  localparam logic [VOL_WIDTH:0] STEP_EXT = (VOL_WIDTH + 1)'(RAMP_STEP);

  pwm_state_e           state_q, state_d;
  logic [VOL_WIDTH-1:0] level_q, level_d;
  logic [VOL_WIDTH-1:0] duty_q, duty_d;
  logic                 pwm_q, pwm_d;
  logic                 shutdown_n_q, shutdown_n_d;
  logic                 sample_req_q, sample_req_d;

  logic [VOL_WIDTH-1:0] cnt;
  logic                 period_end;
  logic                 sample_end;
  logic [VOL_WIDTH:0]   level_up;
  logic [VOL_WIDTH-1:0] level_up_sat;
  logic [VOL_WIDTH:0]   level_dn;

  audio_pwm_period_counter #(
    .CNT_WIDTH          (VOL_WIDTH),
    .PERIODS_PER_SAMPLE (PERIODS_PER_SAMPLE)
  ) u_period_counter (
    .clk_audio  (clk_audio),
    .reset      (reset),
    .run        (state_q != ST_IDLE),
    .clear_rep  (state_q != ST_PLAY),
    .cnt        (cnt),
    .period_end (period_end),
    .sample_end (sample_end)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    duty_d       = duty_q;
    shutdown_n_d = shutdown_n_q;
    sample_req_d = 1'b0;

    // One extra bit so level+step cannot wrap before the clamp.
    level_up     = {1'b0, level_q} + STEP_EXT;
    level_up_sat = (level_up >= INIT_EXT) ? INIT_EXT[VOL_WIDTH-1:0] : level_up[VOL_WIDTH-1:0];
    level_dn     = ({1'b0, level_q} > STEP_EXT) ? {1'b0, level_q} - STEP_EXT : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_RAMP_UP;
          shutdown_n_d = 1'b1;
          level_d      = '0;
          duty_d       = '0;
        end
      end
      ST_RAMP_UP: begin
        if (period_end) begin
          if (!enable) begin
            state_d = ST_RAMP_DOWN;
          end else begin
            level_d = level_up_sat;
            duty_d  = level_up_sat;
            if (level_up_sat == INIT_EXT[VOL_WIDTH-1:0]) state_d = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (period_end) begin
          if (!enable) begin
            state_d = ST_RAMP_DOWN;
            level_d = duty_q;
          end else if (sample_end) begin
            duty_d       = vol;
            sample_req_d = 1'b1;
          end
        end
      end
      ST_RAMP_DOWN: begin
        if (period_end) begin
          if (enable) begin
            state_d = ST_RAMP_UP;
          end else if (level_q == '0) begin
            state_d      = ST_IDLE;
            shutdown_n_d = 1'b0;
          end else begin
            level_d = level_dn[VOL_WIDTH-1:0];
            duty_d  = level_dn[VOL_WIDTH-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pwm_d = (state_q != ST_IDLE) && (cnt < duty_q);
  end

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      duty_q       <= '0;
      pwm_q        <= 1'b0;
      shutdown_n_q <= 1'b0;
      sample_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
      shutdown_n_q <= shutdown_n_d;
      sample_req_q <= sample_req_d;
    end
  end

  assign pwm        = pwm_q;
  assign shutdown_n = shutdown_n_q;
  assign sample_req = sample_req_q;

endmodule

// File: tb/tb_audio_pwm_encoder.sv
// Directed bench for audio_pwm_encoder: one instance with one period per sample,
// one with four periods per sample; per-period high counts are checked against hand values.
module tb_audio_pwm_encoder;

  logic       clk_audio = 1'b0;
  logic       reset     = 1'b1;
  logic       enable    = 1'b1;
  logic [7:0] vol       = 8'd200;
  logic       pwm, sample_req, shutdown_n;
  logic       pwm4, sample_req4, shutdown_n4;

  int n_cmp = 0;
  int n_bad = 0;

  audio_pwm_encoder #(
    .VOL_WIDTH(8), .INITIAL_VOLUME(128), .RAMP_STEP(16), .PERIODS_PER_SAMPLE(1)
  ) dut (
    .clk_audio(clk_audio), .reset(reset), .enable(enable), .vol(vol),
    .sample_req(sample_req), .pwm(pwm), .shutdown_n(shutdown_n)
  );

  audio_pwm_encoder #(
    .VOL_WIDTH(8), .INITIAL_VOLUME(128), .RAMP_STEP(16), .PERIODS_PER_SAMPLE(4)
  ) dut4 (
    .clk_audio(clk_audio), .reset(reset), .enable(enable), .vol(vol),
    .sample_req(sample_req4), .pwm(pwm4), .shutdown_n(shutdown_n4)
  );

  always #5 clk_audio = ~clk_audio;

  // Observes one 256-cycle PWM period window; optionally changes vol/enable after sample pos.
  task automatic measure(input int pos, input logic [7:0] nvol, input logic nen,
                         output int hi, output int req, output int rpos, output logic sd,
                         output int hi4, output int req4);
    hi = 0; req = 0; rpos = -1; hi4 = 0; req4 = 0; sd = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_audio);
      if (pwm === 1'b1) hi++;
      if (sample_req === 1'b1) begin req++; rpos = i; end
      if (pwm4 === 1'b1) hi4++;
      if (sample_req4 === 1'b1) req4++;
      if (i == 255) sd = shutdown_n;
      if (i == pos) begin vol = nvol; enable = nen; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; vol = 8'd200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_audio);
      n_cmp++;
      if (pwm !== 1'b0 || shutdown_n !== 1'b0 || sample_req !== 1'b0 || shutdown_n4 !== 1'b0) begin
        n_bad++;
        $display("FAIL reset cycle %0d: pwm=%b sd=%b req=%b sd4=%b, want all 0",
                 c, pwm, shutdown_n, sample_req, shutdown_n4);
      end
    end
    reset = 1'b0;
    @(negedge clk_audio);
    n_cmp++;
    if (shutdown_n !== 1'b1 || pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: sd=%b pwm=%b, want sd=1 pwm=0", shutdown_n, pwm);
    end
  endtask

  task automatic test_ramp_up();
    int hi, req, rpos, hi4, req4; logic sd;
    for (int p = 0; p < 8; p++) begin
      measure(999, vol, 1'b1, hi, req, rpos, sd, hi4, req4);
      n_cmp++;
      if (hi !== 16 * p || req !== 0 || sd !== 1'b1) begin
        n_bad++;
        $display("FAIL ramp_up period %0d: high=%0d req=%0d sd=%b, want high=%0d req=0 sd=1",
                 p, hi, req, sd, 16 * p);
      end
    end
    measure(999, vol, 1'b1, hi, req, rpos, sd, hi4, req4);
    n_cmp++;
    if (hi !== 128 || req !== 1 || rpos !== 255) begin
      n_bad++;
      $display("FAIL first_play: high=%0d req=%0d at %0d, want high=128 req=1 at 255", hi, req, rpos);
    end
  endtask

  task automatic test_play();
    int hi, req, rpos, hi4, req4; logic sd;
    int         pos_t[4] = '{10, 255, 999, 5};
    logic [7:0] vol_t[4] = '{8'd0, 8'd255, 8'd255, 8'd200};
    int         exp_t[4] = '{200, 0, 0, 255};
    for (int k = 0; k < 4; k++) begin
      measure(pos_t[k], vol_t[k], 1'b1, hi, req, rpos, sd, hi4, req4);
      n_cmp++;
      if (hi !== exp_t[k] || req !== 1 || rpos !== 255) begin
        n_bad++;
        $display("FAIL play window %0d: high=%0d req=%0d at %0d, want high=%0d req=1 at 255",
                 k, hi, req, rpos, exp_t[k]);
      end
    end
  endtask

  task automatic test_ramp_down();
    int hi, req, rpos, hi4, req4, exp_hi; logic sd;
    measure(100, 8'd200, 1'b0, hi, req, rpos, sd, hi4, req4);
    n_cmp++;
    if (hi !== 200 || req !== 0) begin
      n_bad++;
      $display("FAIL drop_window: high=%0d req=%0d, want high=200 req=0", hi, req);
    end
    for (int k = 0; k < 14; k++) begin
      exp_hi = (k == 0) ? 200 : ((k <= 12) ? 200 - 16 * k : 0);
      measure(999, vol, 1'b0, hi, req, rpos, sd, hi4, req4);
      n_cmp++;
      if (hi !== exp_hi || req !== 0 || sd !== (k != 13)) begin
        n_bad++;
        $display("FAIL ramp_down period %0d: high=%0d req=%0d sd=%b, want high=%0d req=0 sd=%b",
                 k, hi, req, sd, exp_hi, k != 13);
      end
    end
    measure(999, vol, 1'b0, hi, req, rpos, sd, hi4, req4);
    n_cmp++;
    if (hi !== 0 || req !== 0 || sd !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_ramp: high=%0d req=%0d sd=%b, want 0 0 0", hi, req, sd);
    end
  endtask

  task automatic test_reenable();
    int hi, req, rpos, hi4, req4; logic sd;
    int         pos_t[6] = '{20, 50, 50, 999, 999, 999};
    logic [7:0] vol_t[6] = '{8'd104, 8'd104, 8'd104, 8'd104, 8'd104, 8'd104};
    logic       en_t[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int         exp_t[6] = '{128, 104, 104, 104, 120, 128};
    int         req_t[6] = '{1, 0, 0, 0, 0, 1};
    enable = 1'b1;
    @(negedge clk_audio);
    for (int p = 0; p < 8; p++) begin
      measure(999, vol, 1'b1, hi, req, rpos, sd, hi4, req4);
      n_cmp++;
      if (hi !== 16 * p) begin
        n_bad++;
        $display("FAIL reenable_ramp period %0d: high=%0d, want %0d", p, hi, 16 * p);
      end
    end
    for (int k = 0; k < 6; k++) begin
      measure(pos_t[k], vol_t[k], en_t[k], hi, req, rpos, sd, hi4, req4);
      n_cmp++;
      if (hi !== exp_t[k] || req !== req_t[k] || sd !== 1'b1) begin
        n_bad++;
        $display("FAIL reenable window %0d: high=%0d req=%0d sd=%b, want high=%0d req=%0d sd=1",
                 k, hi, req, sd, exp_t[k], req_t[k]);
      end
    end
  endtask

  task automatic test_reset_mid_play();
    for (int i = 0; i < 100; i++) @(negedge clk_audio);
    n_cmp++;
    if (pwm !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_pwm: pwm=%b, want 1", pwm);
    end
    reset = 1'b1; enable = 1'b0;
    @(negedge clk_audio);
    n_cmp++;
    if (pwm !== 1'b0 || shutdown_n !== 1'b0 || sample_req !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_play_reset: pwm=%b sd=%b req=%b, want 0 0 0", pwm, shutdown_n, sample_req);
    end
    @(negedge clk_audio);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_audio);
      n_cmp++;
      if (pwm !== 1'b0 || shutdown_n !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_hold cycle %0d: pwm=%b sd=%b, want 0 0", c, pwm, shutdown_n);
      end
    end
  endtask

  task automatic test_pps4();
    int hi, req, rpos, hi4, req4; logic sd;
    int exp_hi[9]  = '{128, 128, 128, 128, 200, 200, 200, 200, 50};
    int exp_req[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    reset = 1'b1; enable = 1'b1; vol = 8'd200;
    @(negedge clk_audio);
    @(negedge clk_audio);
    reset = 1'b0;
    @(negedge clk_audio);
    for (int p = 0; p < 8; p++) begin
      measure(999, vol, 1'b1, hi, req, rpos, sd, hi4, req4);
      n_cmp++;
      if (hi4 !== 16 * p || req4 !== 0) begin
        n_bad++;
        $display("FAIL pps4_ramp period %0d: high=%0d req=%0d, want high=%0d req=0",
                 p, hi4, req4, 16 * p);
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 5) measure(30, 8'd50, 1'b1, hi, req, rpos, sd, hi4, req4);
      else        measure(999, vol, 1'b1, hi, req, rpos, sd, hi4, req4);
      n_cmp++;
      if (hi4 !== exp_hi[k] || req4 !== exp_req[k]) begin
        n_bad++;
        $display("FAIL pps4 window %0d: high=%0d req=%0d, want high=%0d req=%0d",
                 k, hi4, req4, exp_hi[k], exp_req[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_play();
    test_ramp_down();
    test_reenable();
    test_reset_mid_play();
    test_pps4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
